batcharger_controller: RTL
==========================

Name: batcharger_controller

Overview:
Digital sequencer for the battery charger power stage. Consumes ADC samples of battery voltage and current and drives the stage's mode enables (tc, cc, cv) and CV target code. It runs the trickle → constant-current → constant-voltage → end-of-charge flow, with a per-phase timeout and automatic recharge. Sits in the digital domain between the ADC front end and the power block.

Parameters:
TMR_W, 16, width of the per-phase timeout counter and the tmax input

Ports:
clk  input  1  system clock
rstz  input  1  asynchronous active-low reset
en  input  1  charger enable; deasserting it aborts charging
vtok  input  1  input supply valid (vin sufficiently above vbat)
smp_valid  input  1  one-cycle strobe: vbat/ibat hold a new sample
vbat  input  8  battery voltage code, 51 LSB/V (same scale as vcv)
ibat  input  8  battery current code, 255 = 1C
vcutoff  input  8  trickle/CC boundary voltage code
vtarget  input  8  CV target voltage code
vpreset  input  8  recharge threshold code, applied in END
iend  input  8  CV termination current code
tmax  input  TMR_W  max cycles per phase; 0 disables the timeout
tc  output  1  trickle-current mode enable
cc  output  1  constant-current mode enable
cv  output  1  constant-voltage mode enable
vcv  output  8  latched CV target code to the power stage
state  output  3  IDLE=0, TC=1, CC=2, CV=3, END=4, FAULT=5
done  output  1  charge complete (state END)
fault  output  1  phase timeout (state FAULT)

Behaviour:
- Reset (rstz low, async): state=IDLE; tc, cc, cv, done, fault = 0; vcv=0; timer=0; threshold latches=0.
- All outputs are registered Moore decodes of state and update on the same edge as state. At most one of tc/cc/cv is high.
- Priority order each edge: (1) en=0 → IDLE; (2) vtok=0 → IDLE, except FAULT holds; (3) qualifying sample transition; (4) timeout.
- IDLE: on smp_valid with en=1 and vtok=1, latch vcutoff, vtarget, vpreset, iend into internal registers and copy vtarget to vcv. Next state uses vbat:
  - vbat < vcutoff → TC
  - else vbat < vtarget → CC
  - else → END
- Config inputs that change outside IDLE are ignored until the next IDLE exit.
- TC: smp_valid and vbat >= vcutoff_l → CC.
- CC: smp_valid and vbat >= vtarget_l → CV.
- CV: smp_valid and ibat <= iend_l → END.
- END: done=1. smp_valid and vbat < vpreset_l → IDLE; re-evaluation happens on the next sample.
- FAULT: fault=1 and all mode enables 0. Leaves only on en=0 → IDLE.
- All compares are unsigned 8-bit. Transitions are evaluated only on smp_valid cycles; without smp_valid the state holds except for the en/vtok/timeout rules.
- Timer:
  - Cleared to 0 on every state change. Increments each cycle in TC/CC/CV and saturates at all-ones. Held at 0 in other states.
  - Timeout fires when tmax != 0, timer == tmax-1, and no transition occurs that edge. The next state is FAULT, so FAULT is entered exactly tmax cycles after phase entry.
  - A qualifying transition on the same edge as a timeout wins.
- vtok low in TC/CC/CV/END → IDLE next edge; mode enables drop on that edge.

Test Plan:
- Full cycle, vcutoff=153, vtarget=188 (8'b10111100), vpreset=184, iend=13, tmax=0:
  - samples vbat=140 → tc=1, vcv=188
  - vbat=160 → cc=1
  - vbat=188 → cv=1
  - ibat=12 → END, done=1
  - each output changes on the edge of its smp_valid.
- Timeout: tmax=50, hold vbat=140 in TC → FAULT and fault=1 exactly 50 cycles after TC entry, tc=0. Then vtok=0 → stays FAULT; en=0 → IDLE, fault=0.
- Simultaneous events: tmax=20 in CC, smp_valid with vbat=190 on the timeout edge → CV, not FAULT, timer=0.
- Abort: en=0 mid-CV → next edge state=IDLE, cv=0. Separately, vtok=0 mid-CC → IDLE. Assert rstz low mid-TC → all outputs 0 immediately, without waiting for a clock edge.
- Recharge and config latching: in END, change vtarget to 200 → vcv stays 188. Then sample vbat=183 → IDLE. Next sample vbat=183 → CC with vcv=200.
- Boundaries: from IDLE, vbat=153 → CC (not TC). vbat=188 → END directly. ibat=13 in CV → END. ibat=14 → stays CV.

Source files
------------

// File: rtl/batcharger_controller.sv
// Battery charger sequencer: trickle -> constant-current -> constant-voltage -> end of charge,
// with a per-phase timeout into FAULT and automatic recharge from END.
module batcharger_controller #(
    parameter int TMR_W = 16
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             en,
    input  logic             vtok,
    input  logic             smp_valid,
    input  logic [7:0]       vbat,
    input  logic [7:0]       ibat,
    input  logic [7:0]       vcutoff,
    input  logic [7:0]       vtarget,
    input  logic [7:0]       vpreset,
    input  logic [7:0]       iend,
    input  logic [TMR_W-1:0] tmax,
    output logic             tc,
    output logic             cc,
    output logic             cv,
    output logic [7:0]       vcv,
    output logic [2:0]       state,
    output logic             done,
    output logic             fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TC    = 3'd1;
    localparam logic [2:0] S_CC    = 3'd2;
    localparam logic [2:0] S_CV    = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_vcutoff_l;
    logic [7:0]       r_vtarget_l;
    logic [7:0]       r_vpreset_l;
    logic [7:0]       r_iend_l;
    logic [7:0]       r_vcv;
    logic             r_tc;
    logic             r_cc;
    logic             r_cv;
    logic             r_done;
    logic             r_fault;

    logic             w_state_ok;
    logic             w_in_phase;
    logic             w_latch;
    logic             w_smp_hit;
    logic [2:0]       w_smp_state;
    logic [TMR_W-1:0] w_tmax_m1;
    logic             w_timeout;
    logic [2:0]       w_next;
    logic [TMR_W-1:0] w_timer_next;

    assign w_state_ok = (r_state <= S_FAULT);
    assign w_in_phase = (r_state == S_TC) || (r_state == S_CC) || (r_state == S_CV);
    assign w_latch    = (r_state == S_IDLE) && en && vtok && smp_valid;
    assign w_tmax_m1  = tmax - TMR_ONE;
    assign w_timeout  = w_in_phase && (tmax != '0) && (r_timer == w_tmax_m1);

    // IDLE exits compare against the live config; later phases use the copies taken at exit.
    always_comb begin
        w_smp_hit   = 1'b0;
        w_smp_state = r_state;
        if (smp_valid) begin
            case (r_state)
                S_IDLE: begin
                    w_smp_hit = 1'b1;
                    if (vbat < vcutoff) begin
                        w_smp_state = S_TC;
                    end else if (vbat < vtarget) begin
                        w_smp_state = S_CC;
                    end else begin
                        w_smp_state = S_END;
                    end
                end
                S_TC: begin
                    if (vbat >= r_vcutoff_l) begin
                        w_smp_hit   = 1'b1;
                        w_smp_state = S_CC;
                    end
                end
                S_CC: begin
                    if (vbat >= r_vtarget_l) begin
                        w_smp_hit   = 1'b1;
                        w_smp_state = S_CV;
                    end
                end
                S_CV: begin
                    if (ibat <= r_iend_l) begin
                        w_smp_hit   = 1'b1;
                        w_smp_state = S_END;
                    end
                end
                S_END: begin
                    if (vbat < r_vpreset_l) begin
                        w_smp_hit   = 1'b1;
                        w_smp_state = S_IDLE;
                    end
                end
                default: begin
                    w_smp_hit   = 1'b0;
                    w_smp_state = r_state;
                end
            endcase
        end
    end

    // A qualifying sample outranks a timeout on the same edge; FAULT ignores vtok.
    always_comb begin
        w_next = r_state;
        if (!w_state_ok) begin
            w_next = S_IDLE;
        end else if (!en) begin
            w_next = S_IDLE;
        end else if (!vtok && (r_state != S_FAULT)) begin
            w_next = S_IDLE;
        end else if (w_smp_hit) begin
            w_next = w_smp_state;
        end else if (w_timeout) begin
            w_next = S_FAULT;
        end
    end

    always_comb begin
        w_timer_next = '0;
        if ((w_next == r_state) && w_in_phase) begin
            if (&r_timer) begin
                w_timer_next = r_timer;
            end else begin
                w_timer_next = r_timer + TMR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_next;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_vcutoff_l <= 8'd0;
            r_vtarget_l <= 8'd0;
            r_vpreset_l <= 8'd0;
            r_iend_l    <= 8'd0;
            r_vcv       <= 8'd0;
        end else if (w_latch) begin
            r_vcutoff_l <= vcutoff;
            r_vtarget_l <= vtarget;
            r_vpreset_l <= vpreset;
            r_iend_l    <= iend;
            r_vcv       <= vtarget;
        end
    end

    // Mode outputs are decoded from the next state so they move on the same edge as state.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_tc    <= 1'b0;
            r_cc    <= 1'b0;
            r_cv    <= 1'b0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_tc    <= (w_next == S_TC);
            r_cc    <= (w_next == S_CC);
            r_cv    <= (w_next == S_CV);
            r_done  <= (w_next == S_END);
            r_fault <= (w_next == S_FAULT);
        end
    end

    assign tc    = r_tc;
    assign cc    = r_cc;
    assign cv    = r_cv;
    assign done  = r_done;
    assign fault = r_fault;
    assign vcv   = r_vcv;
    assign state = r_state;

endmodule
